// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO multiply/divide sequencer.
// Holds op codes, FSM state encoding, iteration-step modes, the default
// operand width and small op-decode helpers.
// Build option: HILO_DIV_EN enables DIV/DIVU decoding.
package hilo_pkg;

  localparam int unsigned HILO_WIDTH = 32;

  localparam logic [3:0] HILO_OP_NOP   = 4'd0;
  localparam logic [3:0] HILO_OP_MULT  = 4'd1;
  localparam logic [3:0] HILO_OP_MULTU = 4'd2;
  localparam logic [3:0] HILO_OP_MADD  = 4'd3;
  localparam logic [3:0] HILO_OP_MSUB  = 4'd4;
  localparam logic [3:0] HILO_OP_MUL   = 4'd5;
  localparam logic [3:0] HILO_OP_DIV   = 4'd6;
  localparam logic [3:0] HILO_OP_DIVU  = 4'd7;
  localparam logic [3:0] HILO_OP_MTHI  = 4'd8;
  localparam logic [3:0] HILO_OP_MTLO  = 4'd9;

  typedef enum logic [1:0] {
    HILO_ST_IDLE   = 2'd0,
    HILO_ST_CALC   = 2'd1,
    HILO_ST_FINISH = 2'd2
  } hilo_state_e;

  typedef enum logic {
    HILO_MODE_MUL = 1'b0,
    HILO_MODE_DIV = 1'b1
  } hilo_mode_e;

  // Ops that run through CALC/FINISH.
  function automatic logic hilo_is_seq_op(input logic [3:0] op);
    logic r;
    r = (op == HILO_OP_MULT) || (op == HILO_OP_MULTU) || (op == HILO_OP_MADD) ||
        (op == HILO_OP_MSUB) || (op == HILO_OP_MUL);
`ifdef HILO_DIV_EN
    r = r || (op == HILO_OP_DIV) || (op == HILO_OP_DIVU);
`endif
    return r;
  endfunction

  // Ops whose operands are two's complement.
  function automatic logic hilo_is_signed_op(input logic [3:0] op);
    return (op == HILO_OP_MULT) || (op == HILO_OP_MADD) || (op == HILO_OP_MSUB) ||
           (op == HILO_OP_MUL)  || (op == HILO_OP_DIV);
  endfunction

  function automatic logic hilo_is_div_op(input logic [3:0] op);
    return (op == HILO_OP_DIV) || (op == HILO_OP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_muldiv_seq_if.sv
// hilo_muldiv_seq_if: issue/result bundle between EX and the HI/LO sequencer.
//   master (EX side): drives start, op, a, b, flush; reads busy, done, mullo, hi, lo
//   slave  (sequencer): the reverse
interface hilo_muldiv_seq_if #(
  parameter int unsigned WIDTH = hilo_pkg::HILO_WIDTH
);

  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] mullo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, mullo, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, mullo, hi, lo
  );

endinterface

// File: rtl/hilo_iter_unit.sv
// hilo_iter_unit: one combinational iteration of the HI/LO datapath.
//   acc      : 2*WIDTH working register ({partial, multiplier} or {rem, quot})
//   operand  : multiplicand magnitude (mul) or divisor magnitude (div)
//   mode     : shift-add (mul) or restoring shift-subtract (div)
//   acc_next : accumulator after this step
// Build option: HILO_DIV_EN adds the shift-subtract path.
module hilo_iter_unit
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = HILO_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  hilo_mode_e         mode,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   mul_sum;

  // Right-shifting multiply: add multiplicand into the upper half when the
  // multiplier LSB is set, then shift the whole register right by one.
  always_comb begin
    addend  = acc[0] ? operand : '0;
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  end

`ifdef HILO_DIV_EN
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;

  // Restoring divide: shift next dividend bit into the remainder, subtract
  // the divisor, keep the difference only when it did not borrow.
  always_comb begin
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, operand};
  end

  always_comb begin
    acc_next = {mul_sum, acc[WIDTH-1:1]};
    if (mode == HILO_MODE_DIV) begin
      if (!div_diff[WIDTH]) begin
        acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  always_comb begin
    acc_next = {mul_sum, acc[WIDTH-1:1]};
  end
`endif

endmodule

// File: rtl/hilo_muldiv_seq.sv
// hilo_muldiv_seq: multi-cycle HI/LO multiply(-accumulate)/divide sequencer.
// Owns architectural HI/LO, runs one bit per cycle, and stalls EX via busy.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.start/op/a/b : issue strobe, op code, rs/rt operands
//   bus.flush  : abort in-flight op, no write-back
//   bus.busy   : state != IDLE
//   bus.done   : one-cycle pulse in FINISH
//   bus.mullo  : low word of last MUL
//   bus.hi/lo  : architectural HI/LO
// Build option: HILO_DIV_EN enables DIV/DIVU.
module hilo_muldiv_seq
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = HILO_WIDTH
) (
  input logic              clk,
  input logic              rst_n,
  hilo_muldiv_seq_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  hilo_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mullo_q, mullo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef HILO_DIV_EN
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quot_c, rem_c;
`endif

  logic             sgn_c, a_neg_c, b_neg_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic [PW-1:0]    acc_step_c, prod_c, madd_c, msub_c;
  hilo_mode_e       mode_c;

  // Operand magnitudes and sign flags at issue.
  always_comb begin
    sgn_c   = hilo_is_signed_op(bus.op);
    a_neg_c = sgn_c & bus.a[WIDTH-1];
    b_neg_c = sgn_c & bus.b[WIDTH-1];
    a_mag_c = a_neg_c ? (~bus.a + WIDTH'(1)) : bus.a;
    b_mag_c = b_neg_c ? (~bus.b + WIDTH'(1)) : bus.b;
  end

  // Iteration step mode follows the latched op.
  always_comb begin
    mode_c = HILO_MODE_MUL;
`ifdef HILO_DIV_EN
    if (hilo_is_div_op(op_q)) mode_c = HILO_MODE_DIV;
`endif
  end

  hilo_iter_unit #(
    .WIDTH(WIDTH)
  ) u_iter (
    .acc     (acc_q),
    .operand (opnd_q),
    .mode    (mode_c),
    .acc_next(acc_step_c)
  );

  // Sign fixup and accumulate candidates used in FINISH.
  always_comb begin
    prod_c = neg_q ? (~acc_q + PW'(1)) : acc_q;
    madd_c = {hi_q, lo_q} + prod_c;
    msub_c = {hi_q, lo_q} - prod_c;
`ifdef HILO_DIV_EN
    quot_c = neg_q  ? (~acc_q[WIDTH-1:0] + WIDTH'(1))  : acc_q[WIDTH-1:0];
    rem_c  = rneg_q ? (~acc_q[PW-1:WIDTH] + WIDTH'(1)) : acc_q[PW-1:WIDTH];
`endif
  end

  // Next-state, datapath and write-back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mullo_d = mullo_q;
`ifdef HILO_DIV_EN
    rneg_d  = rneg_q;
    dz_d    = dz_q;
`endif

    if (bus.flush) begin
      state_d = HILO_ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        HILO_ST_IDLE: begin
          if (bus.start) begin
            if (hilo_is_seq_op(bus.op)) begin
              op_d    = bus.op;
              cnt_d   = '0;
              neg_d   = a_neg_c ^ b_neg_c;
              acc_d   = {WIDTH'(0), b_mag_c};
              opnd_d  = a_mag_c;
              state_d = HILO_ST_CALC;
`ifdef HILO_DIV_EN
              rneg_d  = a_neg_c;
              dz_d    = (bus.b == '0);
              if (hilo_is_div_op(bus.op)) begin
                acc_d  = {WIDTH'(0), a_mag_c};
                opnd_d = b_mag_c;
              end
`endif
            end else if (bus.op == HILO_OP_MTHI) begin
              hi_d = bus.a;
            end else if (bus.op == HILO_OP_MTLO) begin
              lo_d = bus.a;
            end
          end
        end

        HILO_ST_CALC: begin
          acc_d = acc_step_c;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = HILO_ST_FINISH;
          end
        end

        HILO_ST_FINISH: begin
          state_d = HILO_ST_IDLE;
          case (op_q)
            HILO_OP_MULT, HILO_OP_MULTU: {hi_d, lo_d} = prod_c;
            HILO_OP_MADD:                {hi_d, lo_d} = madd_c;
            HILO_OP_MSUB:                {hi_d, lo_d} = msub_c;
            HILO_OP_MUL:                 mullo_d = prod_c[WIDTH-1:0];
`ifdef HILO_DIV_EN
            HILO_OP_DIV, HILO_OP_DIVU: begin
              // Divide by zero: quotient all ones, remainder is the dividend.
              lo_d = dz_q ? '1 : quot_c;
              hi_d = rem_c;
            end
`endif
            default: ;
          endcase
        end

        default: state_d = HILO_ST_IDLE;
      endcase
    end

    busy_d = (state_d != HILO_ST_IDLE);
    done_d = (state_d == HILO_ST_FINISH);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HILO_ST_IDLE;
      cnt_q   <= '0;
      op_q    <= HILO_OP_NOP;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      mullo_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef HILO_DIV_EN
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mullo_q <= mullo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef HILO_DIV_EN
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
`endif
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.mullo = mullo_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule
